bus_master_if: RTL
==================

Name: bus_master_if

Overview:
- Master-side initiator for the serial system bus; one instance sits between each local master core and the bus arbiter/master-select mux.
- Accepts one parallel command, requests the bus, and shifts out the 2-bit slave select during the arbiter's slave-select window.
- Then serialises the rw bit, the address and any write data, or deserialises read data, and hands the result back to the core.

Parameters:
ADDR_WIDTH, 12, address bits shifted per transaction
DATA_WIDTH, 8, data bits per transaction
TIMEOUT_CYCLES, 255, read-response wait limit (only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  core command valid
cmd_ready  out  1  high in IDLE only
cmd_rw  in  1  1 = write, 0 = read
cmd_slave  in  2  target slave id
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle pulse when the transaction completes
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
m_request  out  1  bus request to the arbiter
m_grant  in  1  grant from the arbiter
m_busy  in  1  arbiter busy (slave-select phase in progress)
m_slave_select  out  1  serial slave id, LSB first
m_dout  out  1  serial rw/address/write data to the slave
m_dout_valid  out  1  qualifies m_dout
m_din  in  1  serial read data from the slave
m_din_valid  in  1  qualifies m_din

Behaviour:
- Reset: reset low asynchronously forces state IDLE and all outputs to 0 except cmd_ready=1. Shift registers and counters clear. Reset mid-transaction abandons it with no rsp_valid.
- Command capture: when cmd_valid && cmd_ready at a clk edge, latch all cmd_* fields and go to REQ. cmd_ready drops the next cycle.
- States:
  - IDLE:
    - m_request=0.
    - Accept a command as above.
  - REQ:
    - m_request=1; m_slave_select=slave[0].
    - First edge with m_grant=1 -> SEL1.
  - SEL1:
    - m_slave_select=slave[1].
    - Next edge -> WAITB. The arbiter samples bit0 on the grant-seen edge and bit1 on this edge.
  - WAITB:
    - m_slave_select=0.
    - First edge with m_busy=0 -> HDR.
  - HDR:
    - m_dout_valid=1 for 1+ADDR_WIDTH consecutive cycles.
    - Bit order: rw first, then addr LSB first.
    - Then -> WDAT if rw=1, else RDAT.
  - WDAT:
    - m_dout_valid=1 for DATA_WIDTH cycles, wdata LSB first.
    - Then -> DONE.
  - RDAT:
    - m_dout_valid=0.
    - Shift m_din into rdata LSB first on each edge with m_din_valid=1.
    - After DATA_WIDTH valid bits -> DONE. Gaps in m_din_valid are allowed.
  - DONE:
    - m_request=0; rsp_valid=1 for exactly one cycle.
    - rsp_rdata holds the assembled read data (0 for writes); rsp_err=0.
    - Next edge -> IDLE; cmd_ready=1.
- Grant loss: if m_grant falls in SEL1, WAITB, HDR, WDAT or RDAT (pre-emption), go to REQ. Keep m_request=1 and clear the bit counters. The latched command is retried from the start; partial read data is discarded.
- Counters: bit counter width is clog2(ADDR_WIDTH+1). No wrap; each counter reloads on state entry.
- Idle bus: m_request deasserts in DONE, so the arbiter can return to idle or grant another master the next cycle.
- cmd_valid outside IDLE is ignored. No queueing.

Optional Feature:
- Macro: BUS_MASTER_READ_TIMEOUT_EN.
- Defined:
  - In RDAT, a wait counter increments every cycle without m_din_valid and clears on each valid bit.
  - On reaching TIMEOUT_CYCLES -> DONE with rsp_err=1 and rsp_rdata=0.
- Undefined:
  - RDAT waits indefinitely. rsp_err is tied to 0.

Test Plan:
- Write: slave=2'b10, addr=12'h0A5, wdata=8'h3C; grant 2 cycles after request; busy high 3 cycles.
  - slave_select=0 on grant-seen edge, then 1.
  - m_dout stream 1,1,0,1,0,0,1,0,1,0,0,0,0 then 0,0,1,1,1,1,0,0; 21 valid cycles.
  - rsp_valid pulses once; request drops.
- Read: slave=2'b01, addr=12'h001; slave returns 8'hA7 with m_din_valid gaps of 0-3 cycles.
  - 13 header bits out; rsp_rdata=8'hA7, rsp_err=0.
- Pre-emption: drop m_grant midway through WDAT, regrant 4 cycles later.
  - Full restart: slave-select bits resent, header and data resent from bit 0.
  - Exactly one rsp_valid.
- Reset: assert reset during HDR.
  - Asynchronous: all outputs 0 and cmd_ready=1 immediately.
  - No rsp_valid afterwards; next command completes normally.
- Back-to-back: a new cmd_valid held during a transaction is ignored until IDLE.
  - Captured the cycle after DONE; m_request low for at least one cycle between transactions.
- Timeout (BUS_MASTER_READ_TIMEOUT_EN, TIMEOUT_CYCLES=10): read with no m_din_valid.
  - rsp_valid with rsp_err=1 and rsp_rdata=0, 11 cycles after entering RDAT.

Source files
------------

// File: rtl/bus_master_if.sv
// Master-side initiator for the serial system bus: captures one command, arbitrates, then serialises or deserialises it.
// Define BUS_MASTER_READ_TIMEOUT_EN to bound the wait for read data with TIMEOUT_CYCLES.
module bus_master_if #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [1:0]            cmd_slave,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_request,
    input  logic                  m_grant,
    input  logic                  m_busy,
    output logic                  m_slave_select,
    output logic                  m_dout,
    output logic                  m_dout_valid,
    input  logic                  m_din,
    input  logic                  m_din_valid
);

    // One counter serves header and data phases, so size it for the longer of the two.
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, SEL1, WAITB, HDR, WDAT, RDAT, DONE
    } state_t;

    state_t                  state;
    logic                    rw_q;
    logic [1:0]              slave_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_sh;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   data_sh;
    logic [DATA_WIDTH-1:0]   rdata_sh;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    grant_lost;

`ifdef BUS_MASTER_READ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
`else
    // No timeout in this build; TIMEOUT_CYCLES is never negative, so this is constant 0.
    assign rsp_err = (TIMEOUT_CYCLES < 0);
`endif

    assign grant_lost = !m_grant && (state inside {SEL1, WAITB, HDR, WDAT, RDAT});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            m_request      <= 1'b0;
            m_slave_select <= 1'b0;
            m_dout         <= 1'b0;
            m_dout_valid   <= 1'b0;
            rw_q           <= 1'b0;
            slave_q        <= '0;
            addr_q         <= '0;
            addr_sh        <= '0;
            wdata_q        <= '0;
            data_sh        <= '0;
            rdata_sh       <= '0;
            bit_cnt        <= '0;
`ifdef BUS_MASTER_READ_TIMEOUT_EN
            wait_cnt       <= '0;
            rsp_err        <= 1'b0;
`endif
        end else if (grant_lost) begin
            // Pre-empted: keep requesting and replay the latched command from the first slave-select bit.
            state          <= REQ;
            m_request      <= 1'b1;
            m_slave_select <= slave_q[0];
            m_dout         <= 1'b0;
            m_dout_valid   <= 1'b0;
            bit_cnt        <= '0;
            rdata_sh       <= '0;
`ifdef BUS_MASTER_READ_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_q           <= cmd_rw;
                        slave_q        <= cmd_slave;
                        addr_q         <= cmd_addr;
                        wdata_q        <= cmd_wdata;
                        state          <= REQ;
                        cmd_ready      <= 1'b0;
                        m_request      <= 1'b1;
                        m_slave_select <= cmd_slave[0];
                    end
                end
                REQ: begin
                    if (m_grant) begin
                        state          <= SEL1;
                        m_slave_select <= slave_q[1];
                    end
                end
                SEL1: begin
                    state          <= WAITB;
                    m_slave_select <= 1'b0;
                end
                WAITB: begin
                    if (!m_busy) begin
                        state        <= HDR;
                        m_dout_valid <= 1'b1;
                        m_dout       <= rw_q;
                        addr_sh      <= addr_q;
                        bit_cnt      <= '0;
                    end
                end
                HDR: begin
                    if (bit_cnt == CNT_W'(ADDR_WIDTH)) begin
                        bit_cnt <= '0;
                        if (rw_q) begin
                            state   <= WDAT;
                            m_dout  <= wdata_q[0];
                            data_sh <= wdata_q >> 1;
                        end else begin
                            state        <= RDAT;
                            m_dout       <= 1'b0;
                            m_dout_valid <= 1'b0;
                            rdata_sh     <= '0;
`ifdef BUS_MASTER_READ_TIMEOUT_EN
                            wait_cnt     <= '0;
`endif
                        end
                    end else begin
                        m_dout  <= addr_sh[0];
                        addr_sh <= addr_sh >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WDAT: begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state        <= DONE;
                        m_dout       <= 1'b0;
                        m_dout_valid <= 1'b0;
                        m_request    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                    end else begin
                        m_dout  <= data_sh[0];
                        data_sh <= data_sh >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RDAT: begin
`ifdef BUS_MASTER_READ_TIMEOUT_EN
                    if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
                        state     <= DONE;
                        m_request <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else
`endif
                    if (m_din_valid) begin
                        rdata_sh <= {m_din, rdata_sh[DATA_WIDTH-1:1]};
`ifdef BUS_MASTER_READ_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            state     <= DONE;
                            m_request <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= {m_din, rdata_sh[DATA_WIDTH-1:1]};
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef BUS_MASTER_READ_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    cmd_ready <= 1'b1;
`ifdef BUS_MASTER_READ_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
